// File: rtl/vec_mem_arbiter.sv
// Vector RAM sequencer. Three requesters share the single-port RAM, one
// access per cycle, in fixed priority: ROM download writes, then 6502 CPU
// byte accesses, then the AVG instruction fetch, which reads one 16-bit
// word as two byte beats (high byte at the even address first).
//
// Handshakes:
//   cpu_req is a one-cycle strobe. It is captured into a single pending slot
//   and may be granted in the same cycle. cpu_ack pulses two cycles after the
//   grant. A strobe that arrives while the slot is occupied is dropped and
//   sets the sticky cpu_overrun.
//   avg_req is a level request held with a stable avg_addr until avg_valid.
//   avg_valid pulses for one cycle with the full word on avg_inst.
//   The RAM returns mem_rdata one cycle after the address. mem_addr holds its
//   last value when no access is granted.
module vec_mem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DL_OFFSET = 4096
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_overrun,
  input  logic              avg_req,
  input  logic [ADDR_W-2:0] avg_addr,
  output logic [15:0]       avg_inst,
  output logic              avg_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W-1:0] DL_OFF = ADDR_W'(DL_OFFSET);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_HI   = 2'd1,
    F_LO   = 2'd2,
    F_WAIT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_HI   = 2'd2,
    TAG_LO   = 2'd3
  } rd_tag_e;

  fetch_state_e      fetch_state_q;
  rd_tag_e           rd_tag_q, rd_tag_d;

  logic              pend_q, pend_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_wdata_q, pend_wdata_d;
  logic              overrun_q, overrun_d;

  logic              cpu_s1_q;
  logic              cpu_ack_q;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        hi_byte_q;
  logic [15:0]       avg_inst_q;
  logic              avg_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              cpu_has;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_wdata;
  logic              avg_beat;
  logic              grant_dl, grant_cpu, grant_avg;
  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_we_c;
  logic [7:0]        mem_wdata_c;

  // CPU access visible this cycle: the pending slot, or a fresh strobe into an empty slot
  always_comb begin
    cpu_has   = pend_q | cpu_req;
    cur_we    = pend_q ? pend_we_q    : cpu_we;
    cur_addr  = pend_q ? pend_addr_q  : cpu_addr;
    cur_wdata = pend_q ? pend_wdata_q : cpu_wdata;
  end

  // Fixed-priority grant; nothing is granted while reset is asserted
  always_comb begin
    avg_beat  = ((fetch_state_q == F_HI) || (fetch_state_q == F_LO)) && avg_req;
    grant_dl  = rst_l && dl_wr;
    grant_cpu = rst_l && !dl_wr && cpu_has;
    grant_avg = rst_l && !dl_wr && !cpu_has && avg_beat;
  end

  // RAM port mux; the address holds when idle
  always_comb begin
    mem_addr_c  = mem_addr_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = 8'h00;
    if (grant_dl) begin
      mem_addr_c  = dl_addr + DL_OFF;
      mem_we_c    = 1'b1;
      mem_wdata_c = dl_data;
    end else if (grant_cpu) begin
      mem_addr_c  = cur_addr;
      mem_we_c    = cur_we;
      mem_wdata_c = cur_we ? cur_wdata : 8'h00;
    end else if (grant_avg) begin
      mem_addr_c  = {avg_addr, (fetch_state_q == F_LO)};
    end
  end

  // Pending slot next state: capture into an empty slot, drop strobes into a full one
  always_comb begin
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = overrun_q;
    if (pend_q) begin
      if (cpu_req) overrun_d = 1'b1;
      if (grant_cpu) pend_d = 1'b0;
    end else if (cpu_req && !grant_cpu) begin
      pend_d       = 1'b1;
      pend_we_d    = cpu_we;
      pend_addr_d  = cpu_addr;
      pend_wdata_d = cpu_wdata;
    end
  end

  // Read tag: who owns the data the RAM returns next cycle
  always_comb begin
    rd_tag_d = TAG_NONE;
    if (grant_cpu && !cur_we) rd_tag_d = TAG_CPU;
    else if (grant_avg)       rd_tag_d = (fetch_state_q == F_LO) ? TAG_LO : TAG_HI;
  end

  // CPU pending slot and sticky overrun registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      overrun_q    <= overrun_d;
    end
  end

  // Fetch FSM: a preempted beat stays put and retries; dropping avg_req abandons the fetch
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fetch_state_q <= F_IDLE;
    end else begin
      case (fetch_state_q)
        F_IDLE: if (avg_req && !avg_valid_q) fetch_state_q <= F_HI;
        F_HI: begin
          if (!avg_req)       fetch_state_q <= F_IDLE;
          else if (grant_avg) fetch_state_q <= F_LO;
        end
        F_LO: begin
          if (!avg_req)       fetch_state_q <= F_IDLE;
          else if (grant_avg) fetch_state_q <= F_WAIT;
        end
        default:              fetch_state_q <= F_IDLE;
      endcase
    end
  end

  // Read-data steering and completion pulses; the word is published only once both bytes are in
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_tag_q    <= TAG_NONE;
      cpu_s1_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      hi_byte_q   <= 8'h00;
      avg_inst_q  <= 16'h0000;
      avg_valid_q <= 1'b0;
    end else begin
      rd_tag_q    <= rd_tag_d;
      cpu_s1_q    <= grant_cpu;
      cpu_ack_q   <= cpu_s1_q;
      avg_valid_q <= 1'b0;
      case (rd_tag_q)
        TAG_CPU: cpu_rdata_q <= mem_rdata;
        TAG_HI:  hi_byte_q   <= mem_rdata;
        TAG_LO: begin
          avg_inst_q  <= {hi_byte_q, mem_rdata};
          avg_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Remember the last driven address so an idle cycle leaves the bus still
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem_addr_q <= '0;
    end else if (grant_dl || grant_cpu || grant_avg) begin
      mem_addr_q <= mem_addr_c;
    end
  end

  assign mem_addr    = mem_addr_c;
  assign mem_we      = mem_we_c;
  assign mem_wdata   = mem_wdata_c;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_overrun = overrun_q;
  assign avg_inst    = avg_inst_q;
  assign avg_valid   = avg_valid_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: behavioural RAM, shadow memory model,
// expected-response queues drained by a monitor on cpu_ack / avg_valid.
module tb_vec_mem_arbiter;

  localparam int ADDR_W    = 13;
  localparam int DL_OFFSET = 4096;
  localparam int MEM_SIZE  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_overrun;
  logic              avg_req;
  logic [ADDR_W-2:0] avg_addr;
  logic [15:0]       avg_inst;
  logic              avg_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // RAM array seen by the DUT, and the bench's own view of what it must hold
  logic [7:0] ram   [0:MEM_SIZE-1];
  logic [7:0] model [0:MEM_SIZE-1];

  // Scoreboard queues: cpu entries are {is_read, expected byte}
  logic [8:0]  cpu_exp_q[$];
  logic [15:0] avg_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cpu_ack_cnt = 0;

  vec_mem_arbiter #(.ADDR_W(ADDR_W), .DL_OFFSET(DL_OFFSET)) dut (
    .clk(clk), .rst_l(rst_l),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_overrun(cpu_overrun),
    .avg_req(avg_req), .avg_addr(avg_addr), .avg_inst(avg_inst), .avg_valid(avg_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pop and compare whenever the DUT presents a completion
  always @(negedge clk) begin : monitor
    logic [8:0]  ce;
    logic [15:0] ae;
    if (rst_l === 1'b1) begin
      if (cpu_ack === 1'b1) begin
        cpu_ack_cnt++;
        if (cpu_exp_q.size() == 0) check("cpu_ack_unexpected", 32'd1, 32'd0);
        else begin
          ce = cpu_exp_q.pop_front();
          if (ce[8]) check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, ce[7:0]});
        end
      end
      if (avg_valid === 1'b1) begin
        if (avg_exp_q.size() == 0) check("avg_valid_unexpected", 32'd1, 32'd0);
        else begin
          ae = avg_exp_q.pop_front();
          check("avg_inst", {16'd0, avg_inst}, {16'd0, ae});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"},  {19'd0, mem_addr}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
    check({tag, "_cpu_ack"},   {31'd0, cpu_ack}, 32'd0);
    check({tag, "_overrun"},   {31'd0, cpu_overrun}, 32'd0);
    check({tag, "_avg_inst"},  {16'd0, avg_inst}, 32'd0);
    check({tag, "_avg_valid"}, {31'd0, avg_valid}, 32'd0);
  endtask

  // Driver: one CPU strobe from an idle bus, wait for its ack
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] data, input bit check_lat);
    int lat;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    if (we) begin
      model[addr] = data;
      cpu_exp_q.push_back({1'b0, 8'h00});
    end else begin
      cpu_exp_q.push_back({1'b1, model[addr]});
    end
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) lat = c;
      next_cycle();
      cpu_req = 1'b0;
      if (lat >= 0) break;
    end
    if (check_lat) check("cpu_ack_latency", lat, 32'd2);
    else if (lat < 0) check("cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin : main
    int vc, ac, acks0, d, exp_a;
    logic [ADDR_W-2:0] a;
    logic [ADDR_W-1:0] ca;
    logic              cw;
    logic [7:0]        cd;
    bit                avg_active;

    rst_l = 1'b0;
    dl_wr = 1'b1; dl_addr = 13'd5; dl_data = 8'hFF;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    avg_req = 1'b0; avg_addr = '0;

    // Reset state, with a download strobe held to show the bus stays quiet
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    rst_l = 1'b1;

    // Fill the whole RAM through the download port; checks the offset wrap
    for (d = 0; d < MEM_SIZE; d++) begin
      dl_wr = 1'b1; dl_addr = ADDR_W'(d); dl_data = 8'($urandom);
      exp_a = (d + DL_OFFSET) % MEM_SIZE;
      model[exp_a] = dl_data;
      @(negedge clk);
      if (d == 0 || d == 4095 || d == 4096 || d == MEM_SIZE - 1) begin
        check("dl_addr_map", {19'd0, mem_addr}, exp_a);
        check("dl_we", {31'd0, mem_we}, 32'd1);
      end
      next_cycle();
    end
    dl_wr = 1'b0;
    next_cycle();

    // Uncontended fetch
    cpu_access(1'b1, 13'h100, 8'hA5, 1'b1);
    cpu_access(1'b1, 13'h101, 8'h3C, 1'b1);
    avg_req = 1'b1; avg_addr = 12'h080;
    avg_exp_q.push_back(16'hA53C);
    vc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) check("fetch_hi_addr", {19'd0, mem_addr}, 32'h100);
      if (c == 2) begin
        check("fetch_lo_addr", {19'd0, mem_addr}, 32'h101);
        check("fetch_lo_we", {31'd0, mem_we}, 32'd0);
      end
      if (avg_valid === 1'b1 && vc < 0) vc = c;
      next_cycle();
      if (vc == c) avg_req = 1'b0;
    end
    check("fetch_latency", vc, 32'd4);

    // CPU write lands between the two beats
    avg_req = 1'b1; avg_addr = 12'h080;
    avg_exp_q.push_back({model[13'h100], model[13'h101]});
    vc = -1; ac = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) check("pre_hi_addr", {19'd0, mem_addr}, 32'h100);
      if (c == 2) begin
        check("pre_cpu_addr", {19'd0, mem_addr}, 32'h200);
        check("pre_cpu_we", {31'd0, mem_we}, 32'd1);
        check("pre_cpu_wdata", {24'd0, mem_wdata}, 32'h55);
      end
      if (c == 3) begin
        check("pre_lo_addr", {19'd0, mem_addr}, 32'h101);
        check("pre_lo_we", {31'd0, mem_we}, 32'd0);
      end
      if (cpu_ack === 1'b1 && ac < 0) ac = c;
      if (avg_valid === 1'b1 && vc < 0) vc = c;
      next_cycle();
      cpu_req = 1'b0;
      if (c == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h200; cpu_wdata = 8'h55;
        model[13'h200] = 8'h55;
        cpu_exp_q.push_back({1'b0, 8'h00});
      end
      if (vc == c) avg_req = 1'b0;
    end
    check("pre_cpu_ack_cycle", ac, 32'd4);
    check("pre_fetch_latency", vc, 32'd5);

    // Read after write
    cpu_access(1'b1, 13'h0005, 8'h5A, 1'b1);
    cpu_access(1'b0, 13'h0005, 8'h00, 1'b1);

    // Download priority over a concurrent CPU read, including both wrap points
    ac = -1;
    for (int c = 0; c < 8; c++) begin
      dl_wr = 1'b0; cpu_req = 1'b0;
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        cpu_exp_q.push_back({1'b1, model[13'h0005]});
        dl_wr = 1'b1; dl_addr = 13'h000; dl_data = 8'h77;
      end
      if (c == 1) begin dl_wr = 1'b1; dl_addr = 13'h0FFF; dl_data = 8'h11; end
      if (c == 2) begin dl_wr = 1'b1; dl_addr = 13'h1000; dl_data = 8'h22; end
      if (dl_wr) model[(int'(dl_addr) + DL_OFFSET) % MEM_SIZE] = dl_data;
      @(negedge clk);
      if (c == 0) begin
        check("dlp_addr_0", {19'd0, mem_addr}, 32'h1000);
        check("dlp_we_0", {31'd0, mem_we}, 32'd1);
        check("dlp_wdata_0", {24'd0, mem_wdata}, 32'h77);
      end
      if (c == 1) check("dlp_addr_fff", {19'd0, mem_addr}, 32'h1FFF);
      if (c == 2) check("dlp_addr_1000", {19'd0, mem_addr}, 32'h0000);
      if (c == 3) begin
        check("dlp_cpu_addr", {19'd0, mem_addr}, 32'h0005);
        check("dlp_cpu_we", {31'd0, mem_we}, 32'd0);
      end
      if (cpu_ack === 1'b1 && ac < 0) ac = c;
      next_cycle();
    end
    dl_wr = 1'b0; cpu_req = 1'b0;
    check("dlp_cpu_ack_cycle", ac, 32'd5);

    // Overrun: second strobe while the first is held off by a download
    check("overrun_clear", {31'd0, cpu_overrun}, 32'd0);
    acks0 = cpu_ack_cnt;
    for (int c = 0; c < 12; c++) begin
      dl_wr = (c < 3); dl_addr = 13'h0100; dl_data = 8'h33;
      if (dl_wr) model[13'h1100] = 8'h33;
      cpu_req = 1'b0;
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1000;
        cpu_exp_q.push_back({1'b1, model[13'h1000]});
      end
      if (c == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 8'hEE;
      end
      @(negedge clk);
      if (c == 2) check("overrun_set", {31'd0, cpu_overrun}, 32'd1);
      next_cycle();
    end
    dl_wr = 1'b0; cpu_req = 1'b0;
    check("overrun_one_ack", cpu_ack_cnt - acks0, 32'd1);
    cpu_access(1'b0, 13'h0005, 8'h00, 1'b1);

    // Random mix of downloads, CPU accesses and fetches in disjoint regions
    avg_active = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      cpu_req = 1'b0;
      if (avg_active && avg_exp_q.size() == 0) begin
        avg_req = 1'b0; avg_active = 1'b0;
      end else if (!avg_active && $urandom_range(0, 3) == 0) begin
        a = 12'($urandom_range(12'h100, 12'h1FF));
        avg_addr = a; avg_req = 1'b1; avg_active = 1'b1;
        avg_exp_q.push_back({model[{a, 1'b0}], model[{a, 1'b1}]});
      end
      if (cpu_exp_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        ca = 13'($urandom_range(13'h400, 13'hFFF));
        cw = 1'($urandom_range(0, 1));
        cd = 8'($urandom);
        cpu_req = 1'b1; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        if (cw) begin
          model[ca] = cd;
          cpu_exp_q.push_back({1'b0, 8'h00});
        end else begin
          cpu_exp_q.push_back({1'b1, model[ca]});
        end
      end
      dl_wr = ($urandom_range(0, 3) == 0);
      if (dl_wr) begin
        dl_addr = 13'($urandom_range(0, 13'hFFF));
        dl_data = 8'($urandom);
        model[(int'(dl_addr) + DL_OFFSET) % MEM_SIZE] = dl_data;
      end
      @(negedge clk);
      if (dl_wr) begin
        check("rnd_dl_addr", {19'd0, mem_addr}, (int'(dl_addr) + DL_OFFSET) % MEM_SIZE);
        check("rnd_dl_we", {31'd0, mem_we}, 32'd1);
      end else if (cpu_req) begin
        check("rnd_cpu_same_cycle", {19'd0, mem_addr}, {19'd0, cpu_addr});
      end
      next_cycle();
    end
    dl_wr = 1'b0; cpu_req = 1'b0;
    for (int c = 0; c < 200 && (cpu_exp_q.size() != 0 || avg_exp_q.size() != 0); c++) begin
      if (avg_exp_q.size() == 0) avg_req = 1'b0;
      next_cycle();
    end
    avg_req = 1'b0;
    check("drain_cpu", cpu_exp_q.size(), 32'd0);
    check("drain_avg", avg_exp_q.size(), 32'd0);
    next_cycle();

    // Read back download-written bytes end to end
    for (int i = 0; i < 8; i++) begin
      ca = 13'($urandom_range(13'h1000, 13'h1FFF));
      cpu_access(1'b0, ca, 8'h00, 1'b1);
    end
    check("overrun_sticky", {31'd0, cpu_overrun}, 32'd1);

    // Reset in the middle of a fetch
    avg_req = 1'b1; avg_addr = 12'h010;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("rst_pre_hi_addr", {19'd0, mem_addr}, 32'h020);
    next_cycle();
    rst_l = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clk);
      check("midrst_no_valid", {31'd0, avg_valid}, 32'd0);
    end
    next_cycle();
    rst_l = 1'b1;
    avg_exp_q.push_back({model[13'h020], model[13'h021]});
    vc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) check("rst_restart_hi", {19'd0, mem_addr}, 32'h020);
      if (c == 2) check("rst_restart_lo", {19'd0, mem_addr}, 32'h021);
      if (avg_valid === 1'b1 && vc < 0) vc = c;
      next_cycle();
      if (vc == c) avg_req = 1'b0;
    end
    check("rst_restart_latency", vc, 32'd4);
    check("rst_overrun_cleared", {31'd0, cpu_overrun}, 32'd0);
    check("final_avg_q", avg_exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
